// File: rtl/fp_div.sv
// Sequential FP16 divider: y = a / b via restoring division, one quotient bit per cycle.
// Special-case, denormal and guard-bit rounding rules match the companion FP16 multiplier.
module fp_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y,
  output logic        dz
);

  localparam int FP16_WIDTH = 16;
  localparam int FP16_BIAS  = 15;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] FIN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [FP16_WIDTH-2:0] magA_q, magA_d, magB_q, magB_d;
  logic                  sign_q, sign_d;
  logic signed [7:0]     eq_q, eq_d;
  logic [10:0]           mb_q, mb_d;
  logic [11:0]           rem_q, rem_d;
  logic [11:0]           q_q, q_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [FP16_WIDTH-1:0] y_q, y_d;
  logic                  dz_q, dz_d;
  logic                  special_q, special_d;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) lzc11 = 4'(10 - i);
    end
  endfunction

  logic [4:0]        expA, expB;
  logic [10:0]       sigA, sigB, maNorm, mbNorm;
  logic [3:0]        lzA, lzB;
  logic signed [7:0] ea, eb, eqRaw;
  logic              aInfNan, bInfNan, aZero, bZero;

  assign expA    = magA_q[14:10];
  assign expB    = magB_q[14:10];
  assign aInfNan = &expA;
  assign bInfNan = &expB;
  assign aZero   = (magA_q == '0);
  assign bZero   = (magB_q == '0);

  // Denormals get a zero hidden bit and E = -14, then are left-normalized like normals.
  assign sigA   = {|expA, magA_q[9:0]};
  assign sigB   = {|expB, magB_q[9:0]};
  assign lzA    = lzc11(sigA);
  assign lzB    = lzc11(sigB);
  assign maNorm = sigA << lzA;
  assign mbNorm = sigB << lzB;
  assign ea     = ((expA == 5'd0) ? -8'sd14 : $signed({3'b000, expA}) - 8'(FP16_BIAS))
                  - $signed({4'b0000, lzA});
  assign eb     = ((expB == 5'd0) ? -8'sd14 : $signed({3'b000, expB}) - 8'(FP16_BIAS))
                  - $signed({4'b0000, lzB});
  assign eqRaw  = ea - eb;

  logic                  isSpecial, specDz;
  logic [FP16_WIDTH-1:0] specY;

  always_comb begin
    isSpecial = 1'b1;
    specDz    = 1'b0;
    specY     = {sign_q, 5'h1F, 10'd0};
    if (aInfNan || bInfNan) begin
      specDz = 1'b0;
    end else if (bZero) begin
      specDz = 1'b1;
    end else if (aZero) begin
      specY = {sign_q, 15'd0};
    end else begin
      isSpecial = 1'b0;
    end
  end

  logic        remGe;
  logic [11:0] remSub;

  assign remGe  = (rem_q >= {1'b0, mb_q});
  assign remSub = rem_q - (remGe ? {1'b0, mb_q} : 12'd0);

  // q[11] is always set, so folding the rounding carry back into bit 10 keeps {1, mant} intact.
  logic [11:0]           qRnd;
  logic [10:0]           sigR;
  logic signed [7:0]     eqAdj;
  logic signed [8:0]     efield, shiftAmt;
  logic [9:0]            denorm;
  logic [FP16_WIDTH-1:0] finY;

  assign qRnd     = {1'b0, q_q[11:1]} + {11'd0, q_q[0]};
  assign sigR     = qRnd[10:0] | {qRnd[11], 10'd0};
  assign eqAdj    = eq_q + $signed({7'd0, qRnd[11]});
  assign efield   = {eqAdj[7], eqAdj} + 9'(FP16_BIAS);
  assign shiftAmt = 9'sd1 - efield;
  assign denorm   = 10'(sigR >> shiftAmt[3:0]);

  always_comb begin
    finY = {sign_q, 5'd0, denorm};
    if (efield >= 9'sd31) begin
      finY = {sign_q, 5'h1F, 10'd0};
    end else if (efield >= 9'sd1) begin
      finY = {sign_q, efield[4:0], sigR[9:0]};
    end else if (shiftAmt >= 9'sd11) begin
      finY = {sign_q, 15'd0};
    end
  end

  always_comb begin
    state_d   = state_q;
    magA_d    = magA_q;
    magB_d    = magB_q;
    sign_d    = sign_q;
    eq_d      = eq_q;
    mb_d      = mb_q;
    rem_d     = rem_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    dz_d      = dz_q;
    special_d = special_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          magA_d  = a[14:0];
          magB_d  = b[14:0];
          sign_d  = a[15] ^ b[15];
          state_d = PREP;
        end
      end
      PREP: begin
        special_d = isSpecial;
        if (isSpecial) begin
          y_d     = specY;
          dz_d    = specDz;
          state_d = FIN;
        end else begin
          dz_d = 1'b0;
          mb_d = mbNorm;
          // Pre-doubling a smaller dividend guarantees the first quotient bit is 1.
          if (maNorm < mbNorm) begin
            rem_d = {maNorm, 1'b0};
            eq_d  = eqRaw - 8'sd1;
          end else begin
            rem_d = {1'b0, maNorm};
            eq_d  = eqRaw;
          end
          q_d     = 12'd0;
          cnt_d   = 4'd11;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = remSub << 1;
        q_d   = {q_q[10:0], remGe};
        if (cnt_q == 4'd0) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FIN: begin
        if (!special_q) y_d = finY;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      magA_q    <= '0;
      magB_q    <= '0;
      sign_q    <= 1'b0;
      eq_q      <= '0;
      mb_q      <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      dz_q      <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      magA_q    <= magA_d;
      magB_q    <= magB_d;
      sign_q    <= sign_d;
      eq_q      <= eq_d;
      mb_q      <= mb_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      dz_q      <= dz_d;
      special_q <= special_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign dz        = dz_q;

endmodule
